// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Summary  : State encoding and default timing constants for stopwatch_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int STATE_W             = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_CLR_CYCLES      = 1000000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Summary  : 2-FF synchroniser, stability-counter debouncer and rising-edge
//            press pulse for one raw pushbutton.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_5MHz,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only advances while the synchronised input disagrees with
    // the accepted level; any agreeing cycle restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Summary  : Run/pause/lap/clear sequencer driving the stopwatch counter
//            chain enable, synchronous clear and display hold strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CLR_CYCLES      = DEF_CLR_CYCLES
) (
    input  logic               clk_5MHz,
    input  logic               reset,
    input  logic               btn_ss,
    input  logic               btn_lr,
    input  logic               tc,
    output logic               count_en,
    output logic               count_clr,
    output logic               disp_hold,
    output logic [STATE_W-1:0] state
);

    localparam int               CLR_W    = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);

    logic             ss_p;
    logic             lr_p;
    state_t           state_q;
    state_t           state_d;
    logic [CLR_W-1:0] clr_cnt_q;
    logic [CLR_W-1:0] clr_cnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbnc_ss (
        .clk_5MHz (clk_5MHz),
        .reset    (reset),
        .btn_i    (btn_ss),
        .press_o  (ss_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbnc_lr (
        .clk_5MHz (clk_5MHz),
        .reset    (reset),
        .btn_i    (btn_lr),
        .press_o  (lr_p)
    );

    // Outside CLEAR the countdown is held at its load value, so it is
    // already primed on whichever edge enters CLEAR.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = CLR_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (ss_p)      state_d = ST_RUN;
                else if (lr_p) state_d = ST_CLEAR;
            end
            ST_RUN: begin
                if (tc)        state_d = ST_DONE;
                else if (ss_p) state_d = ST_PAUSE;
                else if (lr_p) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (tc)        state_d = ST_DONE;
                else if (ss_p) state_d = ST_PAUSE;
                else if (lr_p) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (ss_p)      state_d = ST_RUN;
                else if (lr_p) state_d = ST_CLEAR;
            end
            ST_DONE: begin
                if (lr_p)      state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_cnt_q == '0) state_d   = ST_IDLE;
                else                 clr_cnt_d = clr_cnt_q - CLR_W'(1);
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // tc gates the enable combinationally so no tick slips past 4:59.9.
    assign count_en  = ((state_q == ST_RUN) || (state_q == ST_LAP)) && !tc;
    assign count_clr = (state_q == ST_CLEAR);
    assign disp_hold = (state_q == ST_LAP);
    assign state     = state_q;

endmodule

`default_nettype wire
